pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter and return-address unit for the next core generation.
- Replaces the fixed 12-bit PC register, incrementer, offset adder, PC source mux and single-purpose stack with one block.
- Adds:
  - configurable PC, offset and stack widths;
  - sign-extended relative branches;
  - a stall input;
  - stack depth tracking with overflow/underflow detection.
- Sits between the controller (source select, push/pop, stall) and the instruction memory (drives the fetch address).

Parameters:
- PC_WIDTH, 12, width of PC, jump target and stack entries.
- OFFSET_WIDTH, 8, width of the signed relative-branch offset (must be <= PC_WIDTH).
- STACK_DEPTH, 8, number of return-address entries (power of two, >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- stall  in  1  hold all state this cycle.
- pc_src  in  2  next-PC source: PLUS1=0, CONST=1, OFFSET=2, STACK=3.
- push  in  1  push pc_plus1 onto the return stack (call).
- pop  in  1  pop the return stack (return).
- jump_target  in  PC_WIDTH  absolute target for CONST.
- offset  in  OFFSET_WIDTH  two's-complement offset for OFFSET.
- pc  out  PC_WIDTH  current PC (instruction memory address).
- pc_plus1  out  PC_WIDTH  pc+1, combinational.
- stack_level  out  $clog2(STACK_DEPTH)+1  valid entries, 0..STACK_DEPTH.
- stack_overflow  out  1  sticky error flag.
- stack_underflow  out  1  sticky error flag.

Behaviour:
- Reset (rst==0 at a clk edge): pc=0, stack_level=0, both flags=0. Stack contents are don't-care. Reset wins over stall and every other input.
- All PC arithmetic is modulo 2^PC_WIDTH:
  - pc_plus1 = pc+1, so all-ones wraps to 0;
  - OFFSET target = pc_plus1 + sign_extend(offset);
  - example: pc=0x005, offset=0xFC gives next pc 0x002.
- Next PC by pc_src:
  - PLUS1: pc_plus1.
  - CONST: jump_target.
  - OFFSET: the branch target above.
  - STACK: top entry (most recently pushed).
- Update: when stall==0, pc <= next PC at the clk edge (one-cycle latency). When stall==1, pc, stack, stack_level and flags hold, and push/pop are ignored.
- push alone, not full: write pc_plus1 at the top, stack_level+1.
- pop alone, not empty: stack_level-1. The popped value is only consumed when pc_src==STACK; pop with any other pc_src discards the entry.
- pc_src==STACK without pop: peek. PC loads the top entry and stack_level is unchanged.
- push and pop in the same cycle with stack_level>0: top entry replaced by pc_plus1, stack_level unchanged, PC gets the old top if pc_src==STACK.
- push and pop in the same cycle with stack_level==0: treated as underflow, push dropped.
- Underflow (pop, or pc_src==STACK, while stack_level==0):
  - stack_underflow<=1;
  - stack_level stays 0;
  - if pc_src==STACK, next pc = pc_plus1 (fall-through).
- Overflow (push while stack_level==STACK_DEPTH): behaviour set by the optional feature below.
- Flags are sticky and cleared only by reset.

Optional Feature:
- Macro: PC_UNIT_CIRCULAR_STACK_EN.
- Defined: the stack is a circular buffer. A push when full overwrites the oldest entry, stack_level stays STACK_DEPTH, and stack_overflow is tied 0.
- Not defined: a push when full is dropped, stack_level stays STACK_DEPTH, stack_overflow<=1, and pc still updates normally.

Decomposition:
- Package pc_unit_pkg holds:
  - typedef enum logic [1:0] pc_src_t {PC_SRC_PLUS1, PC_SRC_CONST, PC_SRC_OFFSET, PC_SRC_STACK};
  - localparam defaults for PC_WIDTH, OFFSET_WIDTH, STACK_DEPTH.
- One sub-module: return_stack (parametrised storage array, pointer, level, full/empty, circular-mode handling). pc_unit keeps the PC register, arithmetic, source mux and flags.

Test Plan:
- Reset then 3 cycles PLUS1 -> pc 0,1,2,3. Assert stall for 2 cycles -> pc holds 3. Drive rst=0 with stall=1 -> pc=0 next edge.
- pc=0x010, OFFSET with offset=0x05 -> pc=0x016. From 0x016 with offset=0xF0 -> pc=0x007. CONST 0xFFF then PLUS1 -> pc=0x000.
- Nested calls:
  - at pc 0x020: CONST 0x100 + push -> level 1;
  - at pc 0x100: CONST 0x200 + push -> level 2;
  - STACK+pop -> pc 0x101, level 1;
  - STACK+pop -> pc 0x021, level 0.
- STACK+pop at level 0, pc=0x030 -> pc=0x031, stack_underflow=1, stays 1 through 10 further cycles.
- STACK_DEPTH=4: push 5 times (pc_plus1 values A..E), then pop 4 with STACK.
  - Macro undefined: pcs D,C,B,A, overflow=1.
  - Macro defined: E,D,C,B, overflow=0.
- Level 2 with top=0x050, pc=0x070: push+pop+STACK -> pc=0x050, level 2. Next STACK+pop -> pc=0x071.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and default sizes for the program-counter unit.
// Optional build macro used by this slice: PC_UNIT_CIRCULAR_STACK_EN.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        PC_SRC_PLUS1  = 2'd0,
        PC_SRC_CONST  = 2'd1,
        PC_SRC_OFFSET = 2'd2,
        PC_SRC_STACK  = 2'd3
    } pc_src_t;

    localparam int DEFAULT_PC_WIDTH     = 12;
    localparam int DEFAULT_OFFSET_WIDTH = 8;
    localparam int DEFAULT_STACK_DEPTH  = 8;

endpackage

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses with a fill level.
// The write pointer always names the next free slot, so the top entry sits at ptr-1.
// With PC_UNIT_CIRCULAR_STACK_EN defined, a push while full overwrites the oldest
// entry (which is exactly the slot the pointer names once the buffer has wrapped);
// otherwise such a push is dropped. push and pop arrive already qualified by stall.
module return_stack
    import pc_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_PC_WIDTH,
    parameter int DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           write_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    top_idx;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    assign top_idx = ptr - AW'(1);
    assign top     = mem[top_idx];
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);

    // Decode the requested operation; push+pop on an empty stack does nothing here.
    always_comb begin
        do_replace = push && pop && !empty;
        do_pop     = pop && !push && !empty;
`ifdef PC_UNIT_CIRCULAR_STACK_EN
        do_push    = push && !pop;
`else
        do_push    = push && !pop && !full;
`endif
    end

    // Pointer and fill level; level saturates at DEPTH when a full push wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr   <= '0;
            level <= '0;
        end else if (do_push) begin
            ptr <= ptr + AW'(1);
            if (!full) begin
                level <= level + LW'(1);
            end
        end else if (do_pop) begin
            ptr   <= top_idx;
            level <= level - LW'(1);
        end
    end

    // Entry storage: a push writes the free slot, push+pop rewrites the top in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (do_push) begin
                mem[ptr] <= write_data;
            end else if (do_replace) begin
                mem[top_idx] <= write_data;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter, incrementer, relative-branch adder, next-PC mux,
// return-address stack and sticky stack error flags.
// Optional build macro: PC_UNIT_CIRCULAR_STACK_EN (circular return stack, no overflow flag).
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int PC_WIDTH     = DEFAULT_PC_WIDTH,
    parameter int OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH,
    parameter int STACK_DEPTH  = DEFAULT_STACK_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [1:0]                    pc_src,
    input  logic                          push,
    input  logic                          pop,
    input  logic [PC_WIDTH-1:0]           jump_target,
    input  logic [OFFSET_WIDTH-1:0]       offset,
    output logic [PC_WIDTH-1:0]           pc,
    output logic [PC_WIDTH-1:0]           pc_plus1,
    output logic [$clog2(STACK_DEPTH):0]  stack_level,
    output logic                          stack_overflow,
    output logic                          stack_underflow
);

    pc_src_t             src;
    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] stack_top;
    logic [PC_WIDTH-1:0] next_pc;
    logic                stack_empty;
    logic                underflow_event;

    assign src           = pc_src_t'(pc_src);
    assign pc_plus1      = pc + PC_WIDTH'(1);
    assign offset_ext    = PC_WIDTH'($signed(offset));
    assign branch_target = pc_plus1 + offset_ext;
    assign stack_empty   = (stack_level == '0);

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk        (clk),
        .rst        (rst),
        .push       (push && !stall),
        .pop        (pop && !stall),
        .write_data (pc_plus1),
        .top        (stack_top),
        .level      (stack_level)
    );

    // Next-PC source mux; a return from an empty stack falls through to pc+1.
    always_comb begin
        next_pc = pc_plus1;
        case (src)
            PC_SRC_PLUS1:  next_pc = pc_plus1;
            PC_SRC_CONST:  next_pc = jump_target;
            PC_SRC_OFFSET: next_pc = branch_target;
            PC_SRC_STACK:  next_pc = stack_empty ? pc_plus1 : stack_top;
            default:       next_pc = pc_plus1;
        endcase
    end

    // PC register: reset dominates, stall freezes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= '0;
        end else if (!stall) begin
            pc <= next_pc;
        end
    end

    assign underflow_event = !stall && stack_empty && (pop || (src == PC_SRC_STACK));

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stack_underflow <= 1'b0;
        end else if (underflow_event) begin
            stack_underflow <= 1'b1;
        end
    end

`ifdef PC_UNIT_CIRCULAR_STACK_EN
    assign stack_overflow = 1'b0;
`else
    logic stack_full;
    assign stack_full = (stack_level == ($clog2(STACK_DEPTH) + 1)'(STACK_DEPTH));

    // Sticky overflow flag set by a lone push into a full stack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stack_overflow <= 1'b0;
        end else if (!stall && push && !pop && stack_full) begin
            stack_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed, table-driven bench for pc_unit (PC_WIDTH=12, OFFSET_WIDTH=8,
// STACK_DEPTH=4). Expectations follow PC_UNIT_CIRCULAR_STACK_EN when it is defined.
module tb_pc_unit;

    localparam int PW = 12;
    localparam int OW = 8;
    localparam int SD = 4;
    localparam int LW = 3;

`ifdef PC_UNIT_CIRCULAR_STACK_EN
    localparam bit CIRC = 1'b1;
`else
    localparam bit CIRC = 1'b0;
`endif

    localparam logic [1:0] S_PLUS1  = 2'd0;
    localparam logic [1:0] S_CONST  = 2'd1;
    localparam logic [1:0] S_OFFSET = 2'd2;
    localparam logic [1:0] S_STACK  = 2'd3;

    typedef struct {
        logic          rst;
        logic          stall;
        logic [1:0]    src;
        logic          push;
        logic          pop;
        logic [PW-1:0] jt;
        logic [OW-1:0] off;
        logic [PW-1:0] exp_pc;
        logic [LW-1:0] exp_lvl;
        logic          exp_ovf;
        logic          exp_udf;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          stall;
    logic [1:0]    pc_src;
    logic          push;
    logic          pop;
    logic [PW-1:0] jump_target;
    logic [OW-1:0] offset;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_plus1;
    logic [LW-1:0] stack_level;
    logic          stack_overflow;
    logic          stack_underflow;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    pc_unit #(
        .PC_WIDTH     (PW),
        .OFFSET_WIDTH (OW),
        .STACK_DEPTH  (SD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .pc_src          (pc_src),
        .push            (push),
        .pop             (pop),
        .jump_target     (jump_target),
        .offset          (offset),
        .pc              (pc),
        .pc_plus1        (pc_plus1),
        .stack_level     (stack_level),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic st, input logic [1:0] s,
                                input logic pu, input logic po, input logic [PW-1:0] j,
                                input logic [OW-1:0] o, input logic [PW-1:0] epc,
                                input logic [LW-1:0] el, input logic eo, input logic eu);
        vec_t v;
        v.rst = r; v.stall = st; v.src = s; v.push = pu; v.pop = po;
        v.jt = j; v.off = o; v.exp_pc = epc; v.exp_lvl = el;
        v.exp_ovf = eo; v.exp_udf = eu;
        return v;
    endfunction

    // Drive one cycle of inputs, then clock the design once.
    task automatic applyStimulus(input vec_t v);
        rst         = v.rst;
        stall       = v.stall;
        pc_src      = v.src;
        push        = v.push;
        pop         = v.pop;
        jump_target = v.jt;
        offset      = v.off;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the vector's expected values.
    task automatic checkOutput(input vec_t v, input string name);
        logic [PW-1:0] exp_p1;
        exp_p1 = v.exp_pc + PW'(1);
        checks++;
        if (pc !== v.exp_pc) begin
            errors++;
            $display("[TB] FAIL %s pc: got %h expected %h", name, pc, v.exp_pc);
        end
        checks++;
        if (pc_plus1 !== exp_p1) begin
            errors++;
            $display("[TB] FAIL %s pc_plus1: got %h expected %h", name, pc_plus1, exp_p1);
        end
        checks++;
        if (stack_level !== v.exp_lvl) begin
            errors++;
            $display("[TB] FAIL %s stack_level: got %0d expected %0d", name, stack_level, v.exp_lvl);
        end
        checks++;
        if (stack_overflow !== v.exp_ovf) begin
            errors++;
            $display("[TB] FAIL %s stack_overflow: got %b expected %b", name, stack_overflow, v.exp_ovf);
        end
        checks++;
        if (stack_underflow !== v.exp_udf) begin
            errors++;
            $display("[TB] FAIL %s stack_underflow: got %b expected %b", name, stack_underflow, v.exp_udf);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput(v, name);
    endtask

    initial begin
        logic [PW-1:0] exp_pc;
        rst = 1'b0; stall = 1'b0; pc_src = S_PLUS1; push = 1'b0; pop = 1'b0;
        jump_target = '0; offset = '0;

        // rst stall src push pop jt off | pc lvl ovf udf
        vecs.push_back(mk(0, 0, S_PLUS1,  0, 0, 12'h000, 8'h00, 12'h000, 0, 0, 0)); // reset
        vecs.push_back(mk(1, 0, S_PLUS1,  0, 0, 12'h000, 8'h00, 12'h001, 0, 0, 0));
        vecs.push_back(mk(1, 0, S_PLUS1,  0, 0, 12'h000, 8'h00, 12'h002, 0, 0, 0));
        vecs.push_back(mk(1, 0, S_PLUS1,  0, 0, 12'h000, 8'h00, 12'h003, 0, 0, 0));
        vecs.push_back(mk(1, 1, S_PLUS1,  0, 0, 12'h000, 8'h00, 12'h003, 0, 0, 0)); // stall
        vecs.push_back(mk(1, 1, S_CONST,  1, 0, 12'h555, 8'h00, 12'h003, 0, 0, 0)); // stall drops push
        vecs.push_back(mk(0, 1, S_CONST,  0, 0, 12'h555, 8'h00, 12'h000, 0, 0, 0)); // reset beats stall
        vecs.push_back(mk(1, 0, S_CONST,  0, 0, 12'h010, 8'h00, 12'h010, 0, 0, 0));
        vecs.push_back(mk(1, 0, S_OFFSET, 0, 0, 12'h000, 8'h05, 12'h016, 0, 0, 0));
        vecs.push_back(mk(1, 0, S_OFFSET, 0, 0, 12'h000, 8'hF0, 12'h007, 0, 0, 0)); // negative
        vecs.push_back(mk(1, 0, S_CONST,  0, 0, 12'hFFF, 8'h00, 12'hFFF, 0, 0, 0));
        vecs.push_back(mk(1, 0, S_PLUS1,  0, 0, 12'h000, 8'h00, 12'h000, 0, 0, 0)); // wrap
        vecs.push_back(mk(1, 0, S_CONST,  0, 0, 12'h020, 8'h00, 12'h020, 0, 0, 0));
        vecs.push_back(mk(1, 0, S_CONST,  1, 0, 12'h100, 8'h00, 12'h100, 1, 0, 0)); // call
        vecs.push_back(mk(1, 0, S_CONST,  1, 0, 12'h200, 8'h00, 12'h200, 2, 0, 0)); // nested call
        vecs.push_back(mk(1, 0, S_STACK,  0, 1, 12'h000, 8'h00, 12'h101, 1, 0, 0)); // return
        vecs.push_back(mk(1, 0, S_STACK,  0, 1, 12'h000, 8'h00, 12'h021, 0, 0, 0)); // return
        vecs.push_back(mk(1, 0, S_CONST,  0, 0, 12'h030, 8'h00, 12'h030, 0, 0, 0));
        vecs.push_back(mk(1, 0, S_STACK,  0, 1, 12'h000, 8'h00, 12'h031, 0, 0, 1)); // underflow

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("row%0d", i));
        end

        // Underflow flag stays set while the PC keeps running.
        for (int i = 0; i < 10; i++) begin
            exp_pc = 12'h032 + PW'(i);
            step(mk(1, 0, S_PLUS1, 0, 0, 12'h000, 8'h00, exp_pc, 0, 0, 1), $sformatf("sticky%0d", i));
        end

        // Push+pop replace, peek, discarding pop, push+pop on empty.
        step(mk(0, 0, S_PLUS1, 0, 0, 12'h000, 8'h00, 12'h000, 0, 0, 0), "rp_reset");
        step(mk(1, 0, S_CONST, 1, 0, 12'h010, 8'h00, 12'h010, 1, 0, 0), "rp_push1");
        step(mk(1, 0, S_CONST, 0, 0, 12'h04F, 8'h00, 12'h04F, 1, 0, 0), "rp_goto");
        step(mk(1, 0, S_CONST, 1, 0, 12'h070, 8'h00, 12'h070, 2, 0, 0), "rp_push2");
        step(mk(1, 0, S_STACK, 1, 1, 12'h000, 8'h00, 12'h050, 2, 0, 0), "rp_swap");
        step(mk(1, 0, S_STACK, 0, 1, 12'h000, 8'h00, 12'h071, 1, 0, 0), "rp_ret");
        step(mk(1, 0, S_STACK, 0, 0, 12'h000, 8'h00, 12'h001, 1, 0, 0), "rp_peek");
        step(mk(1, 0, S_PLUS1, 0, 1, 12'h000, 8'h00, 12'h002, 0, 0, 0), "rp_discard");
        step(mk(1, 0, S_PLUS1, 1, 1, 12'h000, 8'h00, 12'h003, 0, 0, 1), "rp_empty_pp");

        // Five pushes into a four-deep stack, then four returns and one more.
        step(mk(0, 0, S_PLUS1, 0, 0, 12'h000, 8'h00, 12'h000, 0, 0, 0), "ov_reset");
        for (int i = 1; i <= 4; i++) begin
            step(mk(1, 0, S_PLUS1, 1, 0, 12'h000, 8'h00, PW'(i), LW'(i), 0, 0), $sformatf("ov_push%0d", i));
        end
        step(mk(1, 0, S_PLUS1, 1, 0, 12'h000, 8'h00, 12'h005, 4, !CIRC, 0), "ov_push5");
        for (int i = 0; i < 4; i++) begin
            exp_pc = CIRC ? PW'(5 - i) : PW'(4 - i);
            step(mk(1, 0, S_STACK, 0, 1, 12'h000, 8'h00, exp_pc, LW'(3 - i), !CIRC, 0), $sformatf("ov_pop%0d", i));
        end
        exp_pc = CIRC ? 12'h003 : 12'h002;
        step(mk(1, 0, S_STACK, 0, 1, 12'h000, 8'h00, exp_pc, 0, !CIRC, 1), "ov_extra_pop");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
